// File: rtl/bundle_packer.sv
// Dual-issue bundle packer: pairs an ALU instruction (slot 1) with a following
// memory/control instruction (slot 2) into one 32-bit word. A lone ALU op is
// closed with a NOP partner on timeout, flush, or arrival of another ALU op.
module bundle_packer #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_bundle,
    output logic        err_illegal,
    output logic [15:0] bundle_cnt
);

    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [7:0]  TMO = 8'(TIMEOUT);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [7:0]  wait_q, wait_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_bundle_q, out_bundle_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic        out_space, closing, accept, emit;
    logic [31:0] emit_word;
    logic [4:0]  opcode;
    logic        is_a, is_m, is_n;

    // Opcode classification
    always_comb begin
        opcode = in_instr[4:0];
        is_a   = (opcode == 5'b01000) || (opcode == 5'b00101);
        is_m   = (opcode == 5'b01010) || (opcode == 5'b01011) ||
                 (opcode == 5'b11110) || (opcode == 5'b11011);
        is_n   = (opcode == 5'b00000);
    end

    // Handshake: a pending op that must close blocks new input so order is kept
    always_comb begin
        out_space = !out_valid_q || out_ready;
        closing   = (state_q == PEND) && (flush || (wait_q == TMO));
        in_ready  = out_space && !closing;
        accept    = in_valid && in_ready;
    end

    // Next-state, pending register and emit decision
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        wait_d    = wait_q;
        emit      = 1'b0;
        emit_word = '0;
        err_d     = accept && !is_a && !is_m && !is_n;
        unique case (state_q)
            IDLE: begin
                if (accept && is_a) begin
                    pend_d  = in_instr;
                    wait_d  = '0;
                    state_d = PEND;
                end else if (accept && is_m) begin
                    emit      = 1'b1;
                    emit_word = {in_instr, NOP};
                end
            end
            PEND: begin
                if (closing) begin
                    // Without output space everything holds, counter stays saturated
                    if (out_space) begin
                        emit      = 1'b1;
                        emit_word = {NOP, pend_q};
                        state_d   = IDLE;
                        wait_d    = '0;
                    end
                end else if (accept && is_m) begin
                    emit      = 1'b1;
                    emit_word = {in_instr, pend_q};
                    state_d   = IDLE;
                    wait_d    = '0;
                end else if (accept && is_a) begin
                    emit      = 1'b1;
                    emit_word = {NOP, pend_q};
                    pend_d    = in_instr;
                    wait_d    = '0;
                end else if (wait_q < TMO) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: emits only happen with out_space, so nothing is overwritten
    always_comb begin
        out_valid_d  = emit || (out_valid_q && !out_ready);
        out_bundle_d = emit ? emit_word : out_bundle_q;
        cnt_d        = (out_valid_q && out_ready) ? cnt_q + 16'd1 : cnt_q;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            wait_q       <= '0;
            out_valid_q  <= 1'b0;
            out_bundle_q <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            wait_q       <= wait_d;
            out_valid_q  <= out_valid_d;
            out_bundle_q <= out_bundle_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bundle  = out_bundle_q;
    assign err_illegal = err_q;
    assign bundle_cnt  = cnt_q;

endmodule

// File: tb/tb_bundle_packer.sv
// Bench for bundle_packer: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model with a bundle queue.
module tb_bundle_packer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_bundle;
    logic        err_illegal;
    logic [15:0] bundle_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: held ALU op, its idle age, and bundles not yet consumed
    bit          m_pend;
    logic [15:0] m_pv;
    int          m_age;
    logic        m_err;
    logic [15:0] m_cnt;
    logic [31:0] exp_q[$];

    bundle_packer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
        .err_illegal(err_illegal), .bundle_cnt(bundle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // 1 = ALU, 2 = memory/control, 0 = NOP, 3 = illegal
    function automatic int cls_of(input logic [4:0] op);
        case (op)
            5'b01000, 5'b00101:                       return 1;
            5'b01010, 5'b01011, 5'b11110, 5'b11011:   return 2;
            5'b00000:                                 return 0;
            default:                                  return 3;
        endcase
    endfunction

    task automatic model_clear();
        m_pend = 0; m_pv = 16'h0; m_age = 0; m_err = 0; m_cnt = 16'h0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = 16'h0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_bundle", out_bundle, 32'h0);
        chk("rst_err", 32'(err_illegal), 32'h0);
        chk("rst_cnt", 32'(bundle_cnt), 32'h0);
    endtask

    // One clock of stimulus: drive, compare against the model, advance the model
    task automatic step(input logic iv, input logic [15:0] ins, input logic fl, input logic ordy);
        bit space, closing, rdy, acc;
        int c;
        @(negedge clk);
        in_valid = iv; in_instr = ins; flush = fl; out_ready = ordy;
        #1;
        space   = (exp_q.size() == 0) || ordy;
        closing = m_pend && (fl || m_age == TO);
        rdy     = space && !closing;
        acc     = iv && rdy;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_bundle", out_bundle, exp_q[0]);
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        chk("bundle_cnt", 32'(bundle_cnt), 32'(m_cnt));
        if (exp_q.size() != 0 && ordy) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        c = cls_of(ins[4:0]);
        m_err = acc && (c == 3);
        if (closing) begin
            if (space) begin
                exp_q.push_back({16'h0, m_pv});
                m_pend = 0; m_age = 0;
            end
        end else if (acc && c == 1) begin
            if (m_pend) exp_q.push_back({16'h0, m_pv});
            m_pv = ins; m_pend = 1; m_age = 0;
        end else if (acc && c == 2) begin
            exp_q.push_back({ins, m_pend ? m_pv : 16'h0});
            m_pend = 0; m_age = 0;
        end else if (m_pend && m_age < TO) begin
            m_age++;
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [4:0] ops[10];
        logic [4:0] op;
        int r;
        ops = '{5'b01000, 5'b00101, 5'b01000, 5'b00101, 5'b01010,
                5'b01011, 5'b11110, 5'b11011, 5'b00000, 5'b11111};
        r  = $urandom_range(0, 9);
        op = (r == 9) ? 5'($urandom) : ops[r];
        return {11'($urandom), op};
    endfunction

    initial begin
        int lat, errs, seen;
        logic [31:0] tmo_word;

        // Pair: ALU then memory op forms one bundle
        do_reset();
        step(1, 16'h0108, 0, 1);
        step(1, 16'h014A, 0, 1);
        step(0, 16'h0, 0, 0);
        chk("pair_bundle", out_bundle, 32'h014A_0108);
        step(0, 16'h0, 0, 1);
        step(0, 16'h0, 0, 1);
        chk("pair_cnt", 32'(bundle_cnt), 32'h1);

        // Timeout closes a lone ALU op
        do_reset();
        lat = -1; tmo_word = 32'h0;
        step(1, 16'h0025, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            step(0, 16'h0, 0, 1);
            if (out_valid && lat < 0) begin lat = k; tmo_word = out_bundle; end
        end
        chk("tmo_latency", 32'(lat), 32'(TO + 2));
        chk("tmo_bundle", tmo_word, 32'h0000_0025);

        // Back-to-back ALU ops keep program order
        do_reset();
        step(1, 16'h0108, 0, 1);
        step(1, 16'h0208, 0, 1);
        step(1, 16'h001E, 0, 1);
        chk("b2b_first", out_bundle, 32'h0000_0108);
        step(0, 16'h0, 0, 1);
        chk("b2b_second", out_bundle, 32'h001E_0208);

        // Illegal and NOP inputs are dropped
        do_reset();
        errs = 0;
        step(1, 16'h001F, 0, 1);
        step(1, 16'h0000, 0, 1); errs += int'(err_illegal);
        step(0, 16'h0, 0, 1);    errs += int'(err_illegal);
        step(0, 16'h0, 0, 1);    errs += int'(err_illegal);
        chk("ill_pulses", 32'(errs), 32'h1);
        chk("ill_cnt", 32'(bundle_cnt), 32'h0);
        chk("ill_no_bundle", 32'(out_valid), 32'h0);

        // Backpressure with flush pending
        do_reset();
        step(1, 16'h0108, 0, 0);
        step(1, 16'h0208, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 16'h014A, 1, 0);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_hold", out_bundle, 32'h0000_0108);
        end
        step(0, 16'h0, 1, 1);
        step(0, 16'h0, 0, 1);
        chk("bp_flush_valid", 32'(out_valid), 32'h1);
        chk("bp_flush_bundle", out_bundle, 32'h0000_0208);

        // Reset while pending with an unconsumed bundle
        do_reset();
        step(1, 16'h0108, 0, 0);
        step(1, 16'h0208, 0, 0);
        step(0, 16'h0, 0, 0);
        chk("rp_valid_before", 32'(out_valid), 32'h1);
        do_reset();
        seen = 0;
        for (int k = 0; k < 2 * TO + 4; k++) begin
            step(0, 16'h0, 0, 1);
            seen += int'(out_valid);
        end
        chk("rp_nothing_emitted", 32'(seen), 32'h0);
        chk("rp_cnt", 32'(bundle_cnt), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 9) < 7, rand_instr(),
                 $urandom_range(0, 19) < 3, $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
